// File: rtl/sfpp_reconfig_master_0_p2b_encoder.sv
// Packet-to-byte encoder.
// Each Avalon-ST beat is turned into a byte stream. The stream can hold an
// optional channel header, SOP/EOP markers and the payload byte. Any byte
// that collides with a special code is sent as ESC followed by the byte
// XOR 0x20. Output valid follows input valid with no added latency. The
// input beat is consumed only when its final data byte is accepted.
module sfpp_reconfig_master_0_p2b_encoder #(
  parameter int SEND_CHANNEL_ALWAYS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic [7:0] in_channel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  localparam logic [7:0] SOP_BYTE  = 8'h7A;
  localparam logic [7:0] EOP_BYTE  = 8'h7B;
  localparam logic [7:0] CHAN_BYTE = 8'h7C;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    P_START,
    P_CHAN,
    P_CHESC,
    P_CHVAL,
    P_SOP,
    P_EOP,
    P_DESC,
    P_DATA
  } phase_t;

  phase_t     phase_q, phase_d;
  logic       chan_sent_q, chan_sent_d;
  logic [7:0] last_channel_q, last_channel_d;

  phase_t     cur_phase;
  phase_t     next_phase;
  phase_t     data_phase;
  phase_t     tail_phase;
  logic       hdr_req;
  logic       ch_esc;
  logic       data_esc;
  logic       accept;

  // Decode the current beat and choose the byte to present.
  // P_START is never presented on its own. It is replaced by the first byte
  // the beat needs, so a new beat starts with no idle cycle.
  always_comb begin
    hdr_req  = in_startofpacket &&
               ((SEND_CHANNEL_ALWAYS != 0) || !chan_sent_q ||
                (in_channel != last_channel_q));
    ch_esc   = (in_channel >= SOP_BYTE) && (in_channel <= ESC_BYTE);
    data_esc = (in_data >= SOP_BYTE) && (in_data <= ESC_BYTE);

    data_phase = data_esc ? P_DESC : P_DATA;
    tail_phase = in_endofpacket ? P_EOP : data_phase;

    if (phase_q == P_START) begin
      if (hdr_req)               cur_phase = P_CHAN;
      else if (in_startofpacket) cur_phase = P_SOP;
      else                       cur_phase = tail_phase;
    end else begin
      cur_phase = phase_q;
    end

    next_phase = P_START;
    out_data   = '0;
    unique case (cur_phase)
      P_CHAN: begin
        out_data   = CHAN_BYTE;
        next_phase = ch_esc ? P_CHESC : P_CHVAL;
      end
      P_CHESC: begin
        out_data   = ESC_BYTE;
        next_phase = P_CHVAL;
      end
      P_CHVAL: begin
        out_data   = ch_esc ? (in_channel ^ ESC_XOR) : in_channel;
        next_phase = in_startofpacket ? P_SOP : tail_phase;
      end
      P_SOP: begin
        out_data   = SOP_BYTE;
        next_phase = tail_phase;
      end
      P_EOP: begin
        out_data   = EOP_BYTE;
        next_phase = data_phase;
      end
      P_DESC: begin
        out_data   = ESC_BYTE;
        next_phase = P_DATA;
      end
      P_DATA: begin
        out_data   = data_esc ? (in_data ^ ESC_XOR) : in_data;
        next_phase = P_START;
      end
      default: begin
        out_data   = '0;
        next_phase = P_START;
      end
    endcase

    out_valid = in_valid && !reset;
    in_ready  = (cur_phase == P_DATA) && out_ready && !reset;
    accept    = out_valid && out_ready;
  end

  // Compute the next phase and the channel-tracking state.
  // The channel is recorded only when its value byte is accepted.
  always_comb begin
    phase_d        = phase_q;
    chan_sent_d    = chan_sent_q;
    last_channel_d = last_channel_q;
    if (accept) begin
      phase_d = next_phase;
      if (cur_phase == P_CHVAL) begin
        chan_sent_d    = 1'b1;
        last_channel_d = in_channel;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q        <= P_START;
      chan_sent_q    <= 1'b0;
      last_channel_q <= '0;
    end else begin
      phase_q        <= phase_d;
      chan_sent_q    <= chan_sent_d;
      last_channel_q <= last_channel_d;
    end
  end

endmodule

// File: tb/tb_sfpp_reconfig_master_0_p2b_encoder.sv
// Self-checking bench for the p2b encoder.
// The bench drives two instances, one built with SEND_CHANNEL_ALWAYS=0 and
// one built with SEND_CHANNEL_ALWAYS=1. A byte-list reference model predicts
// the output stream of each beat.
module tb_sfpp_reconfig_master_0_p2b_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic [7:0] in_channel;
  logic       out_ready;
  int unsigned sel;

  logic       in_valid0, in_valid1;
  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [7:0] out_data0, out_data1;
  logic       o_valid, o_in_ready;
  logic [7:0] o_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  bit         m_sent[2];
  logic [7:0] m_last[2];

  always #5 clk = ~clk;

  assign in_valid0  = in_valid && (sel == 0);
  assign in_valid1  = in_valid && (sel == 1);
  assign o_valid    = (sel == 0) ? out_valid0 : out_valid1;
  assign o_in_ready = (sel == 0) ? in_ready0  : in_ready1;
  assign o_data     = (sel == 0) ? out_data0  : out_data1;

  sfpp_reconfig_master_0_p2b_encoder #(.SEND_CHANNEL_ALWAYS(0)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_channel(in_channel),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
  );

  sfpp_reconfig_master_0_p2b_encoder #(.SEND_CHANNEL_ALWAYS(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_channel(in_channel),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
  );

  function automatic bit is_special(input logic [7:0] b);
    return (b == 8'h7A) || (b == 8'h7B) || (b == 8'h7C) || (b == 8'h7D);
  endfunction

  function automatic logic [7:0] pick_byte();
    logic [7:0] r;
    r = 8'($urandom);
    if ($urandom_range(2) == 0) r = 8'h7A + 8'($urandom_range(3));
    return r;
  endfunction

  // Build the expected byte list for one beat. Returns 1 if a header is sent.
  function automatic bit build_exp(input bit sop, input bit eop,
                                   input logic [7:0] ch, input logic [7:0] d);
    bit hdr;
    exp_q.delete();
    hdr = sop && ((sel == 1) || !m_sent[sel] || (ch != m_last[sel]));
    if (hdr) begin
      exp_q.push_back(8'h7C);
      if (is_special(ch)) begin
        exp_q.push_back(8'h7D);
        exp_q.push_back(ch ^ 8'h20);
      end else exp_q.push_back(ch);
    end
    if (sop) exp_q.push_back(8'h7A);
    if (eop) exp_q.push_back(8'h7B);
    if (is_special(d)) begin
      exp_q.push_back(8'h7D);
      exp_q.push_back(d ^ 8'h20);
    end else exp_q.push_back(d);
    return hdr;
  endfunction

  // Present one beat and follow its bytes out. With rnd_ready=1, out_ready is
  // randomized, which also checks that the output holds during stalls.
  task automatic run_beat(input bit sop, input bit eop, input logic [7:0] ch,
                          input logic [7:0] d, input bit rnd_ready);
    bit hdr;
    hdr = build_exp(sop, eop, ch, d);
    in_valid = 1'b1; in_startofpacket = sop; in_endofpacket = eop;
    in_channel = ch; in_data = d;
    for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
      out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp_q[0] ||
          o_in_ready !== (out_ready && exp_q.size() == 1)) begin
        errors++;
        $display("FAIL beat_byte dut%0d: valid=%b data=%h in_ready=%b, expected valid=1 data=%h in_ready=%b",
                 sel, o_valid, o_data, o_in_ready, exp_q[0], out_ready && exp_q.size() == 1);
      end
      @(posedge clk); #1;
      if (out_ready) void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL beat_timeout dut%0d: %0d bytes left, expected 0", sel, exp_q.size());
    end
    if (hdr) begin
      m_sent[sel] = 1'b1;
      m_last[sel] = ch;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_startofpacket = 1'b1; in_endofpacket = 1'b1;
    in_channel = 8'h01; in_data = 8'h41;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    m_sent[0] = 1'b0; m_sent[1] = 1'b0;
    m_last[0] = 8'h00; m_last[1] = 8'h00;
  endtask

  task automatic test_reset();
    sel = 0;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_startofpacket = 1'b1; in_endofpacket = 1'b0;
    in_channel = 8'h01; in_data = 8'h00;
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b in_ready=%b, expected 0 0", out_valid0, in_ready0);
    end
    do_reset();
  endtask

  task automatic test_single_beat();
    logic [7:0] exp5 [5];
    exp5 = '{8'h7C, 8'h01, 8'h7A, 8'h7B, 8'h41};
    sel = 0;
    do_reset();
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b1;
    in_channel = 8'h01; in_data = 8'h41; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_data !== exp5[i] || o_valid !== 1'b1 || o_in_ready !== (i == 4)) begin
        errors++;
        $display("FAIL single_beat[%0d]: data=%h valid=%b in_ready=%b, expected %h 1 %b",
                 i, o_data, o_valid, o_in_ready, exp5[i], i == 4);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    m_sent[0] = 1'b1; m_last[0] = 8'h01;
  endtask

  task automatic test_escaped_data();
    sel = 0;
    do_reset();
    run_beat(1, 0, 8'h01, 8'h11, 0);
    run_beat(0, 0, 8'h01, 8'h7A, 0);
    run_beat(0, 1, 8'h01, 8'h22, 0);
    run_beat(1, 1, 8'h01, 8'h33, 0);
    in_valid = 1'b0;
  endtask

  task automatic test_escaped_channel();
    sel = 0;
    do_reset();
    run_beat(1, 0, 8'h7D, 8'h10, 1);
    run_beat(0, 1, 8'h7D, 8'h7C, 1);
    run_beat(1, 1, 8'h02, 8'h20, 1);
    run_beat(1, 1, 8'h7D, 8'h21, 1);
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] exp_d [5];
    bit         rdy   [5];
    int         pulses;
    exp_d = '{8'h7D, 8'h7D, 8'h5B, 8'h5B, 8'h5B};
    rdy   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pulses = 0;
    sel = 0;
    in_valid = 1'b1; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    in_channel = 8'h09; in_data = 8'h7B;
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy[i];
      @(negedge clk);
      if (o_in_ready) pulses++;
      checks++;
      if (o_data !== exp_d[i] || o_in_ready !== (i == 4)) begin
        errors++;
        $display("FAIL stall[%0d]: data=%h in_ready=%b, expected %h %b",
                 i, o_data, o_in_ready, exp_d[i], i == 4);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL stall_pulses: %0d in_ready pulses, expected 1", pulses);
    end
  endtask

  task automatic test_reset_mid_beat();
    sel = 0;
    do_reset();
    run_beat(1, 1, 8'h05, 8'h33, 0);
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b0;
    in_channel = 8'h06; in_data = 8'h44; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_data !== 8'h7C) begin
      errors++;
      $display("FAIL mid_reset_chan: data=%h, expected 7c", o_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: out_valid=%b in_ready=%b, expected 0 0", o_valid, o_in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_sent[0] = 1'b0; m_last[0] = 8'h00;
    m_sent[1] = 1'b0; m_last[1] = 8'h00;
    run_beat(1, 0, 8'h06, 8'h44, 0);
    in_valid = 1'b0;
  endtask

  task automatic test_send_always();
    sel = 1;
    do_reset();
    run_beat(1, 1, 8'h03, 8'h01, 0);
    run_beat(1, 1, 8'h03, 8'h02, 0);
    run_beat(1, 0, 8'h03, 8'h7C, 1);
    run_beat(0, 1, 8'h03, 8'h04, 1);
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] chans [6];
    logic [7:0] ch;
    bit         sop;
    bit         eop;
    chans = '{8'h01, 8'h02, 8'h7A, 8'h7B, 8'h7C, 8'h7D};
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      sop = 1'b1;
      ch = 8'h01;
      for (int n = 0; n < 80; n++) begin
        if (sop) ch = ($urandom_range(3) == 0) ? pick_byte() : chans[$urandom_range(5)];
        eop = ($urandom_range(3) == 0);
        run_beat(sop, eop, ch, pick_byte(), 1);
        sop = eop;
      end
      in_valid = 1'b0;
    end
  endtask

  initial begin
    sel = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_channel = '0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    test_reset();
    test_single_beat();
    test_escaped_data();
    test_escaped_channel();
    test_stall();
    test_reset_mid_beat();
    test_send_always();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
